// File: rtl/fp_vector_sequencer_pkg.sv
// Shared definitions for the vector sequencer: element width and controller state encoding.
package fp_vector_sequencer_pkg;

  localparam int FP_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_vector_sequencer_element_select.sv
// Combinational indexed slice of a packed vector bus; out-of-range index yields zero.
module vector_element_select
  import fp_vector_sequencer_pkg::*;
#(
  parameter int VLEN = 4,
  parameter int IW   = $clog2(VLEN + 1)
) (
  input  logic [FP_WIDTH*VLEN-1:0] i_bus,
  input  logic [IW-1:0]            i_idx,
  output logic [FP_WIDTH-1:0]      o_elem
);

  always_comb begin
    o_elem = '0;
    for (int i = 0; i < VLEN; i++) begin
      if (i_idx == IW'(i)) o_elem = i_bus[FP_WIDTH*i +: FP_WIDTH];
    end
  end

endmodule

// File: rtl/fp_vector_sequencer.sv
// Streams latched element pairs through one shared scalar FP unit and gathers the
// in-order results into a result vector, pulsing o_done when all are captured.
module fp_vector_sequencer
  import fp_vector_sequencer_pkg::*;
#(
  parameter int VLEN            = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [FP_WIDTH*VLEN-1:0] i_vec_a,
  input  logic [FP_WIDTH*VLEN-1:0] i_vec_b,
  output logic [FP_WIDTH-1:0]      o_op_a,
  output logic [FP_WIDTH-1:0]      o_op_b,
  output logic                     o_op_valid,
  input  logic                     i_op_ready,
  input  logic [FP_WIDTH-1:0]      i_res_in,
  input  logic                     i_res_valid,
  output logic [FP_WIDTH*VLEN-1:0] o_result,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output state_t                   o_state
);

  localparam int IW = $clog2(VLEN + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  state_t                    r_state;
  logic [FP_WIDTH*VLEN-1:0]  r_vec_a;
  logic [FP_WIDTH*VLEN-1:0]  r_vec_b;
  logic [FP_WIDTH*VLEN-1:0]  r_result;
  logic [IW-1:0]             r_issue_idx;
  logic [IW-1:0]             r_res_idx;
  logic [OW-1:0]             r_outstanding;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_err;

  logic [FP_WIDTH-1:0] w_sel_a;
  logic [FP_WIDTH-1:0] w_sel_b;
  logic                w_op_valid;
  logic                w_issue;
  logic                w_capture;
  logic                w_last_issue;
  logic                w_last_capture;

  vector_element_select #(.VLEN(VLEN), .IW(IW)) u_sel_a (
    .i_bus (r_vec_a),
    .i_idx (r_issue_idx),
    .o_elem(w_sel_a)
  );

  vector_element_select #(.VLEN(VLEN), .IW(IW)) u_sel_b (
    .i_bus (r_vec_b),
    .i_idx (r_issue_idx),
    .o_elem(w_sel_b)
  );

  // Handshake: a pair transfers on a cycle where o_op_valid && i_op_ready; while
  // valid is high and ready low, valid and the operands hold (they depend only on
  // registers that change on a transfer or on a capture that can only lower outstanding).
  assign w_op_valid     = (r_state == ST_ISSUE) && (r_outstanding < OW'(MAX_OUTSTANDING));
  assign w_issue        = w_op_valid && i_op_ready;
  assign w_capture      = i_res_valid && (r_outstanding != '0) &&
                          ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
  assign w_last_issue   = w_issue && (r_issue_idx == IW'(VLEN - 1));
  assign w_last_capture = w_capture && (r_res_idx == IW'(VLEN - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_vec_a       <= '0;
      r_vec_b       <= '0;
      r_result      <= '0;
      r_issue_idx   <= '0;
      r_res_idx     <= '0;
      r_outstanding <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_issue) r_issue_idx <= r_issue_idx + IW'(1);
      if (w_capture) r_res_idx <= r_res_idx + IW'(1);
      case ({w_issue, w_capture})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      for (int i = 0; i < VLEN; i++) begin
        if (w_capture && (r_res_idx == IW'(i))) r_result[FP_WIDTH*i +: FP_WIDTH] <= i_res_in;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_vec_a       <= i_vec_a;
            r_vec_b       <= i_vec_b;
            r_issue_idx   <= '0;
            r_res_idx     <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_last_capture) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_last_issue) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_last_capture) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // A stray result outranks the clear done by a simultaneous start.
      if (i_res_valid && !w_capture) r_err <= 1'b1;
    end
  end

  assign o_op_valid = w_op_valid;
  assign o_op_a     = w_op_valid ? w_sel_a : '0;
  assign o_op_b     = w_op_valid ? w_sel_b : '0;
  assign o_result   = r_result;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_state    = r_state;

endmodule

// File: tb/tb_fp_vector_sequencer.sv
// Bench for fp_vector_sequencer: a behavioural in-order FP unit with per-op latency
// feeds results back, and whole result vectors are compared against a reference.
module tb_fp_vector_sequencer;
  import fp_vector_sequencer_pkg::*;

  localparam int VLEN = 4;
  localparam int MAXO = 4;
  localparam int W    = 32 * VLEN;

  // ---------------- clock / reset ----------------
  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [W-1:0]  i_vec_a = '0;
  logic [W-1:0]  i_vec_b = '0;
  logic          i_op_ready = 1'b0;
  logic [31:0]   i_res_in = '0;
  logic          i_res_valid = 1'b0;
  logic [31:0]   o_op_a;
  logic [31:0]   o_op_b;
  logic          o_op_valid;
  logic [W-1:0]  o_result;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  state_t        o_state;

  always #5 i_clk = ~i_clk;

  fp_vector_sequencer #(.VLEN(VLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_vec_a    (i_vec_a),
    .i_vec_b    (i_vec_b),
    .o_op_a     (o_op_a),
    .o_op_b     (o_op_b),
    .o_op_valid (o_op_valid),
    .i_op_ready (i_op_ready),
    .i_res_in   (i_res_in),
    .i_res_valid(i_res_valid),
    .o_result   (o_result),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_state    (o_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, n_out = 0, max_out = 0, done_cnt = 0, n_issue = 0;
  int cur_lat = 1, rmode = 0, stall_left = 0, last_due = 0;
  logic [31:0]  fpu_q[$];
  int           due_q[$];
  logic [W-1:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [63:0]  prev_ops = '0;

  // Scalar operator stand-in: any fixed bijective-ish mix of a and b exposes swaps and ordering.
  function automatic logic [31:0] fpu(input logic [31:0] a, input logic [31:0] b);
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic logic [W-1:0] ref_vec(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < VLEN; i++) r[32*i +: 32] = fpu(a[32*i +: 32], b[32*i +: 32]);
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    int due;
    bit hs;
    hs         = o_op_valid && i_op_ready && !i_rst;
    prev_stall = o_op_valid && !i_op_ready && !i_rst;
    prev_ops   = {o_op_a, o_op_b};
    if (hs) begin
      due = cyc + ((cur_lat < 0) ? int'($urandom_range(1, 8)) : cur_lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      fpu_q.push_back(fpu(o_op_a, o_op_b));
      due_q.push_back(due);
      n_out++;
      n_issue++;
      if (n_out > max_out) max_out = n_out;
    end
    @(posedge i_clk);
    cyc++;
    #1;
    if (o_done) done_cnt++;
    if (prev_stall) check_eq("stall_hold", {o_op_valid, o_op_a, o_op_b}, {1'b1, prev_ops});
    case (rmode)
      1: i_op_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (o_op_valid && o_op_a == 32'h40866666 && stall_left > 0) begin
          i_op_ready = 1'b0;
          stall_left--;
        end else begin
          i_op_ready = 1'b1;
        end
      end
      default: i_op_ready = 1'b1;
    endcase
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      i_res_valid = 1'b1;
      i_res_in    = fpu_q.pop_front();
      void'(due_q.pop_front());
      n_out--;
    end else begin
      i_res_valid = 1'b0;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        input int mode, input bit restart, input int exp_lat, input bit hit_max);
    int s, n, d0;
    bit got;
    logic [W-1:0] exp;
    cur_lat = lat; rmode = mode; stall_left = 3; max_out = 0; d0 = done_cnt;
    exp_q.push_back(ref_vec(a, b));
    i_vec_a = a; i_vec_b = b; i_start = 1'b1; s = cyc;
    tick();
    i_start = 1'b0;
    check_eq("first_valid", o_op_valid, 1);
    check_eq("busy_on", o_busy, 1);
    check_eq("err_clr", o_err, 0);
    got = 0; n = 0;
    while (!got && n < 400) begin
      if (restart && n == 1) begin
        i_start = 1'b1;
        i_vec_a = ~a;
      end else begin
        i_start = 1'b0;
      end
      tick();
      n++;
      if (o_done) got = 1;
    end
    i_start = 1'b0;
    exp = exp_q.pop_front();
    check_eq("done_seen", got, 1);
    check_eq("result", o_result, exp);
    check_eq("busy_at_done", o_busy, 0);
    if (exp_lat > 0) check_eq("latency", cyc - s, exp_lat);
    if (hit_max) check_eq("max_out_hit", max_out, MAXO);
    check_eq("max_out_le", max_out <= MAXO, 1);
    repeat (3) tick();
    check_eq("one_done", done_cnt - d0, 1);
    check_eq("err_after", o_err, 0);
    check_eq("idle_after", o_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] a_dir, prev_res, ra;
    int h0, k, d0;
    a_dir = {32'h3E000000, 32'hBF000000, 32'h40866666, 32'h404CCCCD};

    repeat (2) tick();
    check_eq("rst_valid", o_op_valid, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_err", o_err, 0);
    check_eq("rst_op", {o_op_a, o_op_b}, 0);
    check_eq("rst_result", o_result, 0);
    check_eq("rst_state", o_state, ST_IDLE);
    i_rst = 1'b0;
    tick();

    run_op(a_dir, '0, 1, 0, 0, 6, 0);
    run_op(a_dir, '0, 1, 2, 0, 9, 0);
    run_op(a_dir, '0, 6, 0, 0, 11, 1);
    ra = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(ra, {$urandom(), $urandom(), $urandom(), $urandom()}, 2, 0, 1, 0, 0);

    // stray result while idle
    prev_res = o_result;
    i_res_valid = 1'b1;
    i_res_in = 32'h7F800000;
    tick();
    check_eq("idle_res_err", o_err, 1);
    check_eq("idle_res_keep", o_result, prev_res);
    check_eq("idle_res_state", o_state, ST_IDLE);
    run_op({$urandom(), $urandom(), $urandom(), $urandom()}, a_dir, 1, 0, 0, 6, 0);

    // abort after two issues
    cur_lat = 3; rmode = 0; d0 = done_cnt;
    i_vec_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    h0 = n_issue; k = 0;
    while (n_issue - h0 < 2 && k < 50) begin
      tick();
      k++;
    end
    check_eq("abort_issues", n_issue - h0, 2);
    i_rst = 1'b1;
    tick();
    check_eq("abort_valid", o_op_valid, 0);
    check_eq("abort_busy", o_busy, 0);
    check_eq("abort_done", o_done, 0);
    check_eq("abort_err", o_err, 0);
    check_eq("abort_op", {o_op_a, o_op_b}, 0);
    check_eq("abort_result", o_result, 0);
    check_eq("abort_state", o_state, ST_IDLE);
    i_rst = 1'b0;
    repeat (8) tick();
    check_eq("late_res_err", o_err, 1);
    check_eq("abort_no_done", done_cnt - d0, 0);
    run_op(a_dir, {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 0, 0, 6, 0);

    for (int t = 0; t < 8; t++) begin
      run_op({$urandom(), $urandom(), $urandom(), $urandom()},
             {$urandom(), $urandom(), $urandom(), $urandom()}, -1, 1, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_vector_sequencer.md
Name: fp_vector_sequencer

Overview:
Controller that shares one scalar 32-bit floating-point operator (adder, multiplier, etc.) across all elements of a vector operation.
- On start, it latches two VLEN-element vectors and issues element pairs to the operator, one pair per accepted handshake.
- It collects operator results, in order, into a VLEN-element result vector and pulses done.
- It sits between vector sources (test-vector generators, layer buffers) and the scalar FP units in the NN datapath.

Parameters:
VLEN, 4, number of 32-bit elements per vector (>= 1)
MAX_OUTSTANDING, 4, max issued-but-unreturned operations (>= 1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  begin operation; sampled only in IDLE
vec_a  in  32*VLEN  operand A vector, element i at [32*i +: 32]
vec_b  in  32*VLEN  operand B vector, same layout
op_a  out  32  operand A to scalar FP unit
op_b  out  32  operand B to scalar FP unit
op_valid  out  1  operand pair valid
op_ready  in  1  FP unit accepts pair when op_valid && op_ready
res_in  in  32  result from FP unit
res_valid  in  1  res_in valid this cycle; results return in issue order
result  out  32*VLEN  collected result vector, element i at [32*i +: 32]
busy  out  1  high from cycle after accepted start until done cycle, exclusive
done  out  1  one-cycle pulse when all VLEN results are captured
err  out  1  sticky flag: res_valid received with zero outstanding

Behaviour:
- Reset, sync, active-high, dominant over all inputs:
  - state=IDLE; all counters 0; latched vectors 0; result=0.
  - op_valid=0, busy=0, done=0, err=0.
  - op_a/op_b=0.
- States:
  - IDLE: start=1 latches vec_a/vec_b, clears issue_idx, res_idx, outstanding and err, then goes to ISSUE.
  - ISSUE: op_valid=1 when outstanding < MAX_OUTSTANDING; op_a/op_b = latched element issue_idx. On handshake issue_idx++. The handshake on element VLEN-1 moves to DRAIN.
  - DRAIN: op_valid=0; wait for results.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Result collection runs in ISSUE and DRAIN:
  - On res_valid with outstanding>0: result[32*res_idx +: 32] <= res_in, res_idx++.
  - Capture of element VLEN-1 moves the state to DONE in the next cycle.
  - Once res_idx == VLEN, the last capture has priority over ISSUE/DRAIN.
- outstanding:
  - +1 on issue handshake, -1 on capture; simultaneous issue and capture leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Timing: op_valid first asserts the cycle after start is sampled. done asserts the cycle after the last res_valid.
- Minimum latency for an FP unit with fixed latency L (cycles from handshake to res_valid) and op_ready=1: done at start_cycle + VLEN + L + 1, provided MAX_OUTSTANDING >= L.
- op_valid/op_a/op_b must hold stable while op_valid=1 and op_ready=0.
- start while busy or in DONE is ignored; input vectors are not re-sampled.
- res_valid with outstanding==0 (including in IDLE): data ignored, err set. err stays set until rst or the next accepted start.
- result holds its last value between operations. It is only overwritten element-by-element during the next operation.
- VLEN=1: ISSUE lasts until one handshake, then DRAIN.
- rst mid-operation aborts immediately with no done pulse. Late res_valid after reset sets err.
- Counter widths: $clog2(VLEN+1) for indices, $clog2(MAX_OUTSTANDING+1) for outstanding.

Decomposition:
- Shared package holds FP_WIDTH=32 and the state encoding (IDLE, ISSUE, DRAIN, DONE).
- One natural sub-module, vector_element_select: combinational indexed 32-bit slice of a 32*VLEN bus. It is used for op_a and op_b.

Test Plan:
- VLEN=4; vec_a={3.2, 4.2, -0.5, 0.125} (0x404CCCCD, 0x40866666, 0xBF000000, 0x3E000000), vec_b=0; pass-through FP model with L=1, op_ready=1.
  -> op_valid at cycles 1-4; result equals vec_a; done single pulse at cycle 6; err=0.
- Same vectors; op_ready low for 3 cycles while op_a=0x40866666.
  -> op_a/op_b/op_valid stable during the stall; final result still equals vec_a; done delayed by 3 cycles.
- L=6 model, MAX_OUTSTANDING=4.
  -> op_valid drops after the 4th issue until the first result returns; outstanding never exceeds 4; result correct.
- start pulsed again mid-operation with different vec_a.
  -> ignored; result equals the first vec_a; exactly one done.
- res_valid=1 with res_in=0x7F800000 (inf) while IDLE.
  -> err=1, result unchanged; next start clears err.
- rst asserted after 2 issues.
  -> next cycle all outputs 0, state IDLE, no done; a following start completes normally.
